// File: rtl/tcb_vip_sub_mem.sv
// TCB subordinate memory: byte-enabled RAM, DLY-stage response pipe, self-generated backpressure.
// Range/alignment/endianness checks gate the access; transfer and error counters saturate.
module tcb_vip_sub_mem #(
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned DLY = 1,
  parameter int unsigned SIZ = 1024,
  parameter int unsigned BPR = 0,
  parameter int unsigned PER = 3,
  parameter int unsigned CNW = 16,
  localparam int unsigned BYT = DAT / 8,
  localparam int unsigned SZW = ($clog2($clog2(BYT) + 1) > 0) ? $clog2($clog2(BYT) + 1) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tcb_vld,
  output logic           tcb_rdy,
  input  logic           tcb_wen,
  input  logic           tcb_ren,
  input  logic           tcb_ndn,
  input  logic [ADR-1:0] tcb_adr,
  input  logic [SZW-1:0] tcb_siz,
  input  logic [BYT-1:0] tcb_ben,
  input  logic [DAT-1:0] tcb_wdt,
  output logic [DAT-1:0] tcb_rdt,
  output logic [1:0]     tcb_sts,
  output logic           rsp_vld,
  output logic [CNW-1:0] cnt_wr,
  output logic [CNW-1:0] cnt_rd,
  output logic [CNW-1:0] cnt_err
);

  localparam int unsigned OFW = $clog2(BYT);
  localparam int unsigned WDS = SIZ / BYT;
  localparam int unsigned IXW = (WDS > 1) ? $clog2(WDS) : 1;
  localparam int unsigned CW  = (PER > 1) ? $clog2(PER) : 1;

  logic [DAT-1:0] mem_q [WDS];

  logic           trn, err, err0, err1;
  logic [ADR-1:0] amsk;
  logic [IXW-1:0] widx;
  logic [DAT-1:0] bmask, rdt_d;

  logic           vld_q [DLY];
  logic [DAT-1:0] rdt_q [DLY];
  logic [1:0]     sts_q [DLY];
  logic [CNW-1:0] cnt_wr_q, cnt_rd_q, cnt_err_q;

  logic [CW-1:0]  c_q, c_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic           rdy_q, rdy_d;

  assign trn = tcb_vld & rdy_q;

  always_comb begin
    amsk  = (ADR'(1) << tcb_siz) - ADR'(1);
    err0  = (tcb_adr >= ADR'(SIZ)) | (|(tcb_adr & amsk)) | (32'(tcb_siz) > OFW);
    err1  = tcb_ndn;
    err   = err0 | err1;
    widx  = tcb_adr[OFW +: IXW];
    bmask = '0;
    for (int i = 0; i < BYT; i++) bmask[8*i +: 8] = {8{tcb_ben[i]}};
    // Nonblocking memory update makes this the pre-write word when wen and ren coincide.
    rdt_d = (tcb_ren & ~err) ? (mem_q[widx] & bmask) : '0;
  end

  always_ff @(posedge clk) begin
    if (trn & tcb_wen & ~err) begin
      for (int i = 0; i < BYT; i++)
        if (tcb_ben[i]) mem_q[widx][8*i +: 8] <= tcb_wdt[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DLY; k++) begin
        vld_q[k] <= 1'b0;
        rdt_q[k] <= '0;
        sts_q[k] <= '0;
      end
      cnt_wr_q  <= '0;
      cnt_rd_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      vld_q[0] <= trn;
      if (trn) begin
        rdt_q[0] <= rdt_d;
        sts_q[0] <= {err1, err0};
      end
      // Stages load only on a valid token, so the last stage holds between responses.
      for (int k = 1; k < DLY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          rdt_q[k] <= rdt_q[k-1];
          sts_q[k] <= sts_q[k-1];
        end
      end
      if (trn & tcb_wen & ~err & ~&cnt_wr_q) cnt_wr_q  <= cnt_wr_q + 1'b1;
      if (trn & tcb_ren & ~err & ~&cnt_rd_q) cnt_rd_q  <= cnt_rd_q + 1'b1;
      if (trn & err & ~&cnt_err_q)           cnt_err_q <= cnt_err_q + 1'b1;
    end
  end

  always_comb begin
    c_d    = (32'(c_q) == PER - 1) ? '0 : c_q + 1'b1;
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    case (BPR)
      1:       rdy_d = (32'(c_d) == PER - 1);
      2:       rdy_d = lfsr_d[0];
      default: rdy_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      lfsr_q <= 16'hACE1;
      rdy_q  <= 1'b0;
    end else begin
      c_q    <= c_d;
      lfsr_q <= lfsr_d;
      rdy_q  <= rdy_d;
    end
  end

  assign tcb_rdy = rdy_q;
  assign tcb_rdt = rdt_q[DLY-1];
  assign tcb_sts = sts_q[DLY-1];
  assign rsp_vld = vld_q[DLY-1];
  assign cnt_wr  = cnt_wr_q;
  assign cnt_rd  = cnt_rd_q;
  assign cnt_err = cnt_err_q;

endmodule

// File: doc/tcb_vip_sub_mem.md
Name: tcb_vip_sub_mem

Overview:
Synthesizable TCB subordinate memory model with byte enables and a response delay set by a parameter. It generates its own backpressure from a selectable pattern (none, periodic or LFSR), checks address range and alignment, and keeps transfer and error counters. It is the next-generation replacement for the fixed-timing class-based subordinate in VIP benches, and also runs on FPGA/emulation targets where classes are unavailable.

Parameters:
ADR, 32, address width
DAT, 32, data width; power of 2, >=8; BYT=DAT/8
DLY, 1, response delay in cycles after handshake; legal 1..4
SIZ, 1024, memory size in bytes; power of 2, multiple of BYT
BPR, 0, backpressure mode: 0 none, 1 periodic, 2 LFSR
PER, 3, period for BPR=1; legal >=1
CNW, 16, counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tcb_vld  in  1  request valid
tcb_rdy  out  1  request ready
tcb_wen  in  1  write enable
tcb_ren  in  1  read enable
tcb_ndn  in  1  endianness (0 native)
tcb_adr  in  ADR  byte address
tcb_siz  in  $clog2($clog2(BYT)+1)  log2 transfer bytes
tcb_ben  in  BYT  byte enables
tcb_wdt  in  DAT  write data
tcb_rdt  out  DAT  read data
tcb_sts  out  2  status: [0] range/alignment error, [1] unsupported ndn
rsp_vld  out  1  response valid strobe (bench aid)
cnt_wr  out  CNW  accepted write count
cnt_rd  out  CNW  accepted read count
cnt_err  out  CNW  error response count

Behaviour:
- Handshake trn = tcb_vld & tcb_rdy. Exactly one transfer per trn cycle. A request with neither wen nor ren is accepted and responded with sts=0 and rdt=0; no access is made.
- Error check at trn: err0 = (adr >= SIZ) | (adr mod 2**siz != 0) | (siz > log2(BYT)); err1 = ndn.
- If either error is set: no memory write, rdt=0, cnt_err+1.
- Write (wen, no error): mem byte lane i updated at the trn clock edge when ben[i]=1. Lanes are relative to adr aligned down to BYT. Lanes with ben=0 are unchanged.
- Read (ren, no error): the full aligned word is captured at the trn edge. Lanes with ben=0 return 0.
- If wen and ren are both set: write takes effect; rdt returns the pre-write data.
- Read-after-write: a read accepted in the cycle after a write returns the new data.
- Response pipeline has DLY stages of {vld, rdt, sts}. tcb_rdt, tcb_sts and rsp_vld are valid exactly DLY clock edges after the trn edge.
- Between responses, tcb_rdt and tcb_sts hold their last value. rsp_vld is a single-cycle strobe per transfer.
- Back-to-back trn yields back-to-back responses with no bubbles.
- Backpressure source tcb_rdy (registered):
  - BPR=0: tcb_rdy=1 from the first edge after reset release.
  - BPR=1: counter c counts 0..PER-1 and wraps; tcb_rdy=1 only when c==PER-1. With PER=1, tcb_rdy is always 1.
  - BPR=2: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, shifts every cycle; tcb_rdy = lfsr[0].
- tcb_rdy is independent of tcb_vld. Request fields are sampled only on trn; stability under backpressure is not checked here.
- Counters increment on trn: cnt_wr if wen & ~err, cnt_rd if ren & ~err. They saturate at 2**CNW-1.
- Reset (async, rst_n=0):
  - Outputs: tcb_rdy=0, tcb_rdt=0, tcb_sts=0, rsp_vld=0, all counters 0.
  - Internal: pipeline cleared, c=0, LFSR=seed.
  - Memory contents are not reset.
  - Reset during an in-flight response discards that response; no rsp_vld is produced after release.

Test Plan:
- DLY=1, BPR=0: write 32'h01234567 to adr 0x20 with ben=4'hF, then read 0x20 -> rdt=32'h01234567, sts=0, rsp_vld one cycle after each trn; cnt_wr=1, cnt_rd=1.
- Byte lanes: write8 0x23 to adr 0x01 (ben=4'h2, siz=0) over a word of 0, then read32 at 0x00 -> rdt=32'h00002300.
- Errors: read at adr=SIZ -> sts=2'b01, rdt=0; write16 at adr 0x03 -> sts=2'b01 and memory unchanged; ndn=1 -> sts=2'b10; cnt_err=3.
- DLY=3, 8 back-to-back reads of 0x00..0x1C -> 8 consecutive rsp_vld strobes starting 3 cycles after the first trn, with data in request order.
- BPR=1, PER=3, vld held high -> tcb_rdy pattern 0,0,1 repeating; one trn per 3 cycles. BPR=2 -> tcb_rdy sequence matches the reference LFSR model from seed 16'hACE1.
- Assert rst_n=0 for one cycle while DLY=3 has 2 responses in flight -> outputs go to 0 immediately, no rsp_vld afterwards, and memory keeps prior data (read 0x20 still returns 32'h01234567).
